// File: rtl/control_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, FSM states,
// instruction classes and strobe bit positions.
package control_pkg;

   localparam logic [4:0] OP_LD   = 5'd0;
   localparam logic [4:0] OP_LDI  = 5'd1;
   localparam logic [4:0] OP_ST   = 5'd2;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_SHR  = 5'd7;
   localparam logic [4:0] OP_SHL  = 5'd8;
   localparam logic [4:0] OP_ROR  = 5'd9;
   localparam logic [4:0] OP_ROL  = 5'd10;
   localparam logic [4:0] OP_ADDI = 5'd11;
   localparam logic [4:0] OP_ANDI = 5'd12;
   localparam logic [4:0] OP_ORI  = 5'd13;
   localparam logic [4:0] OP_MUL  = 5'd14;
   localparam logic [4:0] OP_DIV  = 5'd15;
   localparam logic [4:0] OP_NEG  = 5'd16;
   localparam logic [4:0] OP_NOT  = 5'd17;
   localparam logic [4:0] OP_BR   = 5'd18;
   localparam logic [4:0] OP_JR   = 5'd19;
   localparam logic [4:0] OP_IN   = 5'd20;
   localparam logic [4:0] OP_OUT  = 5'd21;
   localparam logic [4:0] OP_MFHI = 5'd22;
   localparam logic [4:0] OP_MFLO = 5'd23;
   localparam logic [4:0] OP_NOP  = 5'd26;
   localparam logic [4:0] OP_HALT = 5'd27;

   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_PAUSE
   } state_t;

   typedef enum logic [3:0] {
      C_RTYPE, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_UNARY, C_BR,
      C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT, C_NOP, C_ILL
   } op_class_t;

   // bus_drv bit positions
   localparam int B_ROUT = 0, B_BAOUT = 1, B_HIOUT = 2, B_LOOUT = 3, B_ZHIGH = 4;
   localparam int B_ZLOW = 5, B_PCOUT = 6, B_MDROUT = 7, B_INPORT = 8, B_COUT = 9;
   // reg_ld bit positions
   localparam int L_OUTPORT = 0, L_CONIN = 1, L_RIN = 2, L_MDRIN = 3, L_ZIN = 4, L_LOIN = 5;
   localparam int L_HIIN = 6, L_YIN = 7, L_MARIN = 8, L_IRIN = 9, L_PCIN = 10;
   // alu_op bit positions
   localparam int A_INCPC = 0, A_NOT = 1, A_NEG = 2, A_ROL = 3, A_ROR = 4, A_SHL = 5, A_SHR = 6;
   localparam int A_DIV = 7, A_MUL = 8, A_SUB = 9, A_ADD = 10, A_OR = 11, A_AND = 12;
   // gr_sel bit positions
   localparam int G_GRC = 0, G_GRB = 1, G_GRA = 2;

   function automatic op_class_t classify(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: return C_RTYPE;
         OP_ADDI, OP_ANDI, OP_ORI:       return C_IMM;
         OP_LDI:                         return C_LDI;
         OP_LD:                          return C_LD;
         OP_ST:                          return C_ST;
         OP_MUL, OP_DIV:                 return C_MULDIV;
         OP_NEG, OP_NOT:                 return C_UNARY;
         OP_BR:                          return C_BR;
         OP_JR:                          return C_JR;
         OP_IN:                          return C_IN;
         OP_OUT:                         return C_OUT;
         OP_MFHI:                        return C_MFHI;
         OP_MFLO:                        return C_MFLO;
         OP_HALT:                        return C_HALT;
         OP_NOP:                         return C_NOP;
         default:                        return C_ILL;
      endcase
   endfunction

   function automatic logic [12:0] alu_sel(input logic [4:0] op);
      logic [12:0] a;
      a = '0;
      case (op)
         OP_ADD, OP_ADDI: a[A_ADD] = 1'b1;
         OP_SUB:          a[A_SUB] = 1'b1;
         OP_AND, OP_ANDI: a[A_AND] = 1'b1;
         OP_OR, OP_ORI:   a[A_OR]  = 1'b1;
         OP_SHR:          a[A_SHR] = 1'b1;
         OP_SHL:          a[A_SHL] = 1'b1;
         OP_ROR:          a[A_ROR] = 1'b1;
         OP_ROL:          a[A_ROL] = 1'b1;
         OP_MUL:          a[A_MUL] = 1'b1;
         OP_DIV:          a[A_DIV] = 1'b1;
         OP_NEG:          a[A_NEG] = 1'b1;
         OP_NOT:          a[A_NOT] = 1'b1;
         default:         a = '0;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// 4-bit hold counter: loaded on entry to a held step, counts down to zero
// and sticks there; zero marks the last cycle of the held step.
module ctrl_wait_cnt (
   input  logic       clk,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] count;

   always_ff @(posedge clk or negedge clear) begin
      if (!clear)                     count <= '0;
      else if (load)                  count <= load_val;
      else if (dec && count != 4'd0)  count <= count - 4'd1;
   end

   assign zero = (count == 4'd0);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the 32-bit bus datapath (fetch/decode/execute).
// Optional CTRL_SINGLE_STEP_EN: pause after each instruction until a rising edge on step.
module control_sequencer
   import control_pkg::*;
#(
   parameter int MEM_WAIT    = 1,
   parameter int MULDIV_WAIT = 2
) (
   input  logic        clk,
   input  logic        clear,
   input  logic [4:0]  ir_op,
   input  logic        con_ff,
   input  logic        step,
   output logic [9:0]  bus_drv,
   output logic [10:0] reg_ld,
   output logic [12:0] alu_op,
   output logic [2:0]  gr_sel,
   output logic        read,
   output logic        write,
   output logic        run,
   output logic        instr_done,
   output logic        illegal_op
);

   localparam logic [3:0] MEM_W = 4'(MEM_WAIT);
   localparam logic [3:0] MD_W  = 4'(MULDIV_WAIT);

`ifdef CTRL_SINGLE_STEP_EN
   localparam state_t S_FIN = S_PAUSE;
`else
   localparam state_t S_FIN = S_T0;
`endif

   state_t     state, nxt;
   logic [4:0] op_q;
   logic       take_q, step_q;
   logic       load, dec, zero;
   logic [3:0] load_val;
   op_class_t  cls, cls_t2;

   assign cls    = classify(op_q);
   assign cls_t2 = classify(ir_op);

`ifdef CTRL_SINGLE_STEP_EN
   logic step_rise;
   assign step_rise = step & ~step_q;
`else
   logic unused_step;
   assign unused_step = step ^ step_q;
`endif

   ctrl_wait_cnt u_wait (
      .clk      (clk),
      .clear    (clear),
      .load     (load),
      .load_val (load_val),
      .dec      (dec),
      .zero     (zero)
   );

   always_comb begin
      nxt      = state;
      load     = 1'b0;
      load_val = 4'd0;
      dec      = 1'b0;
      case (state)
         S_RST: nxt = S_T0;
         S_T0: begin nxt = S_T1; load = 1'b1; load_val = MEM_W; end
         S_T1: if (zero) nxt = S_T2; else dec = 1'b1;
         S_T2: nxt = (cls_t2 == C_NOP || cls_t2 == C_ILL) ? S_FIN : S_T3;
         S_T3:
            case (cls)
               C_HALT:                            nxt = S_HALT;
               C_JR, C_IN, C_OUT, C_MFHI, C_MFLO: nxt = S_FIN;
               C_MULDIV: begin nxt = S_T4; load = 1'b1; load_val = MD_W; end
               default:                           nxt = S_T4;
            endcase
         S_T4:
            case (cls)
               C_MULDIV: if (zero) nxt = S_T5; else dec = 1'b1;
               C_UNARY:  nxt = S_FIN;
               default:  nxt = S_T5;
            endcase
         S_T5:
            case (cls)
               C_LD: begin nxt = S_T6; load = 1'b1; load_val = MEM_W; end
               C_ST, C_MULDIV, C_BR: nxt = S_T6;
               default:              nxt = S_FIN;
            endcase
         S_T6:
            case (cls)
               C_LD: if (zero) nxt = S_T7; else dec = 1'b1;
               C_ST: begin nxt = S_T7; load = 1'b1; load_val = MEM_W; end
               default: nxt = S_FIN;
            endcase
         S_T7:
            if (cls == C_ST && !zero) dec = 1'b1;
            else                      nxt = S_FIN;
`ifdef CTRL_SINGLE_STEP_EN
         S_PAUSE: if (step_rise) nxt = S_T0;
`endif
         default: nxt = state;
      endcase
   end

   // Opcode is captured at decode and the branch condition before the PC update,
   // so every later strobe depends only on registered state.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state  <= S_RST;
         op_q   <= '0;
         take_q <= 1'b0;
         step_q <= 1'b0;
      end else begin
         state  <= nxt;
         step_q <= step;
         if (state == S_T2) op_q   <= ir_op;
         if (state == S_T5) take_q <= con_ff;
      end
   end

   always_comb begin
      bus_drv    = '0;
      reg_ld     = '0;
      alu_op     = '0;
      gr_sel     = '0;
      read       = 1'b0;
      write      = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      run        = (state != S_RST) && (state != S_HALT);
      case (state)
         S_T0: begin
            bus_drv[B_PCOUT] = 1'b1; reg_ld[L_MARIN] = 1'b1;
            alu_op[A_INCPC]  = 1'b1; reg_ld[L_ZIN]   = 1'b1;
         end
         S_T1: begin
            bus_drv[B_ZLOW] = 1'b1; reg_ld[L_PCIN] = 1'b1;
            read            = 1'b1; reg_ld[L_MDRIN] = 1'b1;
         end
         S_T2: begin
            bus_drv[B_MDROUT] = 1'b1; reg_ld[L_IRIN] = 1'b1;
            instr_done = (cls_t2 == C_NOP) || (cls_t2 == C_ILL);
            illegal_op = (cls_t2 == C_ILL);
         end
         S_T3:
            case (cls)
               C_RTYPE, C_IMM: begin gr_sel[G_GRB] = 1'b1; bus_drv[B_ROUT] = 1'b1; reg_ld[L_YIN] = 1'b1; end
               C_LDI, C_LD, C_ST: begin gr_sel[G_GRB] = 1'b1; bus_drv[B_BAOUT] = 1'b1; reg_ld[L_YIN] = 1'b1; end
               C_MULDIV: begin gr_sel[G_GRA] = 1'b1; bus_drv[B_ROUT] = 1'b1; reg_ld[L_YIN] = 1'b1; end
               C_UNARY: begin
                  gr_sel[G_GRB] = 1'b1; bus_drv[B_ROUT] = 1'b1;
                  alu_op = alu_sel(op_q); reg_ld[L_ZIN] = 1'b1;
               end
               C_BR: begin gr_sel[G_GRA] = 1'b1; bus_drv[B_ROUT] = 1'b1; reg_ld[L_CONIN] = 1'b1; end
               C_JR: begin
                  gr_sel[G_GRA] = 1'b1; bus_drv[B_ROUT] = 1'b1; reg_ld[L_PCIN] = 1'b1; instr_done = 1'b1;
               end
               C_IN: begin
                  bus_drv[B_INPORT] = 1'b1; gr_sel[G_GRA] = 1'b1; reg_ld[L_RIN] = 1'b1; instr_done = 1'b1;
               end
               C_OUT: begin
                  gr_sel[G_GRA] = 1'b1; bus_drv[B_ROUT] = 1'b1; reg_ld[L_OUTPORT] = 1'b1; instr_done = 1'b1;
               end
               C_MFHI: begin
                  bus_drv[B_HIOUT] = 1'b1; gr_sel[G_GRA] = 1'b1; reg_ld[L_RIN] = 1'b1; instr_done = 1'b1;
               end
               C_MFLO: begin
                  bus_drv[B_LOOUT] = 1'b1; gr_sel[G_GRA] = 1'b1; reg_ld[L_RIN] = 1'b1; instr_done = 1'b1;
               end
               C_HALT: instr_done = 1'b1;
               default: ;
            endcase
         S_T4:
            case (cls)
               C_RTYPE: begin
                  gr_sel[G_GRC] = 1'b1; bus_drv[B_ROUT] = 1'b1;
                  alu_op = alu_sel(op_q); reg_ld[L_ZIN] = 1'b1;
               end
               C_IMM: begin bus_drv[B_COUT] = 1'b1; alu_op = alu_sel(op_q); reg_ld[L_ZIN] = 1'b1; end
               C_LDI, C_LD, C_ST: begin bus_drv[B_COUT] = 1'b1; alu_op[A_ADD] = 1'b1; reg_ld[L_ZIN] = 1'b1; end
               C_MULDIV: begin
                  gr_sel[G_GRB] = 1'b1; bus_drv[B_ROUT] = 1'b1;
                  alu_op = alu_sel(op_q); reg_ld[L_ZIN] = 1'b1;
               end
               C_UNARY: begin
                  bus_drv[B_ZLOW] = 1'b1; gr_sel[G_GRA] = 1'b1; reg_ld[L_RIN] = 1'b1; instr_done = 1'b1;
               end
               C_BR: begin bus_drv[B_PCOUT] = 1'b1; reg_ld[L_YIN] = 1'b1; end
               default: ;
            endcase
         S_T5:
            case (cls)
               C_RTYPE, C_IMM, C_LDI: begin
                  bus_drv[B_ZLOW] = 1'b1; gr_sel[G_GRA] = 1'b1; reg_ld[L_RIN] = 1'b1; instr_done = 1'b1;
               end
               C_LD, C_ST: begin bus_drv[B_ZLOW] = 1'b1; reg_ld[L_MARIN] = 1'b1; end
               C_MULDIV:   begin bus_drv[B_ZLOW] = 1'b1; reg_ld[L_LOIN] = 1'b1; end
               C_BR: begin bus_drv[B_COUT] = 1'b1; alu_op[A_ADD] = 1'b1; reg_ld[L_ZIN] = 1'b1; end
               default: ;
            endcase
         S_T6:
            case (cls)
               C_LD: begin read = 1'b1; reg_ld[L_MDRIN] = 1'b1; end
               C_ST: begin gr_sel[G_GRA] = 1'b1; bus_drv[B_ROUT] = 1'b1; reg_ld[L_MDRIN] = 1'b1; end
               C_MULDIV: begin bus_drv[B_ZHIGH] = 1'b1; reg_ld[L_HIIN] = 1'b1; instr_done = 1'b1; end
               C_BR: begin
                  bus_drv[B_ZLOW] = take_q; reg_ld[L_PCIN] = take_q; instr_done = 1'b1;
               end
               default: ;
            endcase
         S_T7:
            case (cls)
               C_LD: begin
                  bus_drv[B_MDROUT] = 1'b1; gr_sel[G_GRA] = 1'b1; reg_ld[L_RIN] = 1'b1; instr_done = 1'b1;
               end
               C_ST: begin write = 1'b1; instr_done = zero; end
               default: ;
            endcase
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: table of per-instruction timing plus randomized
// instruction streams compared cycle by cycle against a step-list model.
module tb_control_sequencer;
   import control_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // observed word = {bus_drv, reg_ld, alu_op, gr_sel, read, write, run, instr_done, illegal_op}
   localparam logic [41:0] ILL = 42'(1) << 0,  DONE = 42'(1) << 1, RUN = 42'(1) << 2;
   localparam logic [41:0] WR  = 42'(1) << 3,  RD   = 42'(1) << 4;
   localparam logic [41:0] GRC = 42'(1) << 5,  GRB  = 42'(1) << 6, GRA = 42'(1) << 7;
   localparam logic [41:0] INCPC = 42'(1) << 8, ANOT = 42'(1) << 9, ANEG = 42'(1) << 10;
   localparam logic [41:0] AROL = 42'(1) << 11, AROR = 42'(1) << 12, ASHL = 42'(1) << 13;
   localparam logic [41:0] ASHR = 42'(1) << 14, ADIV = 42'(1) << 15, AMUL = 42'(1) << 16;
   localparam logic [41:0] ASUB = 42'(1) << 17, AADD = 42'(1) << 18, AOR = 42'(1) << 19;
   localparam logic [41:0] AAND = 42'(1) << 20;
   localparam logic [41:0] OUTPORT = 42'(1) << 21, CONIN = 42'(1) << 22, RIN = 42'(1) << 23;
   localparam logic [41:0] MDRIN = 42'(1) << 24, ZIN = 42'(1) << 25, LOIN = 42'(1) << 26;
   localparam logic [41:0] HIIN = 42'(1) << 27, YIN = 42'(1) << 28, MARIN = 42'(1) << 29;
   localparam logic [41:0] IRIN = 42'(1) << 30, PCIN = 42'(1) << 31;
   localparam logic [41:0] ROUT = 42'(1) << 32, BAOUT = 42'(1) << 33, HIOUT = 42'(1) << 34;
   localparam logic [41:0] LOOUT = 42'(1) << 35, ZHIGH = 42'(1) << 36, ZLOW = 42'(1) << 37;
   localparam logic [41:0] PCOUT = 42'(1) << 38, MDROUT = 42'(1) << 39, INPORT = 42'(1) << 40;
   localparam logic [41:0] COUT = 42'(1) << 41;

   logic       clear_a [2];
   logic [4:0] ir_a    [2];
   logic       con_a   [2];
   logic       step;

   logic [9:0]  bus0, bus1;
   logic [10:0] ld0, ld1;
   logic [12:0] alu0, alu1;
   logic [2:0]  gr0, gr1;
   logic        rd0, rd1, wr0, wr1, run0, run1, dn0, dn1, il0, il1;
   logic [41:0] obs [2];
   assign obs[0] = {bus0, ld0, alu0, gr0, rd0, wr0, run0, dn0, il0};
   assign obs[1] = {bus1, ld1, alu1, gr1, rd1, wr1, run1, dn1, il1};

   control_sequencer #(.MEM_WAIT(1), .MULDIV_WAIT(2)) u0 (
      .clk(clk), .clear(clear_a[0]), .ir_op(ir_a[0]), .con_ff(con_a[0]), .step(step),
      .bus_drv(bus0), .reg_ld(ld0), .alu_op(alu0), .gr_sel(gr0), .read(rd0), .write(wr0),
      .run(run0), .instr_done(dn0), .illegal_op(il0));

   control_sequencer #(.MEM_WAIT(3), .MULDIV_WAIT(0)) u1 (
      .clk(clk), .clear(clear_a[1]), .ir_op(ir_a[1]), .con_ff(con_a[1]), .step(step),
      .bus_drv(bus1), .reg_ld(ld1), .alu_op(alu1), .gr_sel(gr1), .read(rd1), .write(wr1),
      .run(run1), .instr_done(dn1), .illegal_op(il1));

   int checks = 0;
   int errors = 0;
   logic [41:0] exp_q[$];

   task automatic chk(input string nm, input logic [41:0] act, input logic [41:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic bit defined_op(input logic [4:0] op);
      logic [4:0] ops [26] = '{OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
                               OP_SHL, OP_ROR, OP_ROL, OP_ADDI, OP_ANDI, OP_ORI, OP_MUL, OP_DIV,
                               OP_NEG, OP_NOT, OP_BR, OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO,
                               OP_NOP, OP_HALT};
      foreach (ops[i]) if (ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [41:0] alu_of(input logic [4:0] op);
      case (op)
         OP_ADD, OP_ADDI: return AADD;
         OP_SUB:          return ASUB;
         OP_AND, OP_ANDI: return AAND;
         OP_OR, OP_ORI:   return AOR;
         OP_SHR: return ASHR;
         OP_SHL: return ASHL;
         OP_ROR: return AROR;
         OP_ROL: return AROL;
         OP_MUL: return AMUL;
         OP_DIV: return ADIV;
         OP_NEG: return ANEG;
         OP_NOT: return ANOT;
         default: return '0;
      endcase
   endfunction

   task automatic push(input logic [41:0] w, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(w | RUN);
   endtask

   // Expected per-cycle outputs for one instruction, T0 through its final step.
   task automatic build(input logic [4:0] op, input bit con, input int mw, input int dw);
      logic [41:0] a;
      a = alu_of(op);
      exp_q.delete();
      push(PCOUT | MARIN | INCPC | ZIN, 1);
      push(ZLOW | PCIN | RD | MDRIN, mw + 1);
      if (!defined_op(op) || op == OP_NOP) begin
         push(MDROUT | IRIN | DONE | (defined_op(op) ? 42'd0 : ILL), 1);
         return;
      end
      push(MDROUT | IRIN, 1);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
            push(GRB | ROUT | YIN, 1); push(GRC | ROUT | a | ZIN, 1); push(ZLOW | GRA | RIN | DONE, 1);
         end
         OP_ADDI, OP_ANDI, OP_ORI: begin
            push(GRB | ROUT | YIN, 1); push(COUT | a | ZIN, 1); push(ZLOW | GRA | RIN | DONE, 1);
         end
         OP_LDI: begin
            push(GRB | BAOUT | YIN, 1); push(COUT | AADD | ZIN, 1); push(ZLOW | GRA | RIN | DONE, 1);
         end
         OP_LD: begin
            push(GRB | BAOUT | YIN, 1); push(COUT | AADD | ZIN, 1); push(ZLOW | MARIN, 1);
            push(RD | MDRIN, mw + 1); push(MDROUT | GRA | RIN | DONE, 1);
         end
         OP_ST: begin
            push(GRB | BAOUT | YIN, 1); push(COUT | AADD | ZIN, 1); push(ZLOW | MARIN, 1);
            push(GRA | ROUT | MDRIN, 1); push(WR, mw); push(WR | DONE, 1);
         end
         OP_MUL, OP_DIV: begin
            push(GRA | ROUT | YIN, 1); push(GRB | ROUT | a | ZIN, dw + 1);
            push(ZLOW | LOIN, 1); push(ZHIGH | HIIN | DONE, 1);
         end
         OP_NEG, OP_NOT: begin
            push(GRB | ROUT | a | ZIN, 1); push(ZLOW | GRA | RIN | DONE, 1);
         end
         OP_BR: begin
            push(GRA | ROUT | CONIN, 1); push(PCOUT | YIN, 1); push(COUT | AADD | ZIN, 1);
            push((con ? (ZLOW | PCIN) : 42'd0) | DONE, 1);
         end
         OP_JR:   push(GRA | ROUT | PCIN | DONE, 1);
         OP_IN:   push(INPORT | GRA | RIN | DONE, 1);
         OP_OUT:  push(GRA | ROUT | OUTPORT | DONE, 1);
         OP_MFHI: push(HIOUT | GRA | RIN | DONE, 1);
         OP_MFLO: push(LOOUT | GRA | RIN | DONE, 1);
         OP_HALT: begin
            push(DONE, 1);
            for (int i = 0; i < 20; i++) exp_q.push_back('0);
         end
         default: ;
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Moves a finished instruction on to the next T0.
   task automatic next_instr(input int k);
`ifdef CTRL_SINGLE_STEP_EN
      chk("pause", obs[k], RUN);
      step = 1'b1;
      tick();
      step = 1'b0;
`else
      chk_i("inst", k, k);
`endif
   endtask

   task automatic rst(input int k);
      clear_a[k] = 1'b0;
      tick();
      chk($sformatf("rst_hold%0d", k), obs[k], '0);
      clear_a[k] = 1'b1;
      chk($sformatf("rst_state%0d", k), obs[k], '0);
      tick();
   endtask

   task automatic run_model(input int k, input logic [4:0] op, input bit con,
                            input int mw, input int dw, input bit adv);
      int c;
      ir_a[k] = op;
      con_a[k] = con;
      build(op, con, mw, dw);
      c = 0;
      while (exp_q.size() > 0) begin
         chk($sformatf("u%0d_op%0d_c%0d", k, op, c), obs[k], exp_q.pop_front());
         c++;
         tick();
      end
      if (adv) next_instr(k);
   endtask

   task automatic run_count(input int k, input logic [4:0] op, input bit con,
                            input int len, input int rds, input int wrs, input int ills);
      int n, r, w, il;
      bit done;
      ir_a[k] = op;
      con_a[k] = con;
      n = 0; r = 0; w = 0; il = 0; done = 1'b0;
      while (!done && n < 60) begin
         n++;
         r  += int'(obs[k][4]);
         w  += int'(obs[k][3]);
         il += int'(obs[k][0]);
         done = obs[k][1];
         tick();
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL timeout_op%0d: no instr_done within %0d cycles", op, n);
      end
      chk_i($sformatf("len_op%0d", op), n, len);
      chk_i($sformatf("reads_op%0d", op), r, rds);
      chk_i($sformatf("writes_op%0d", op), w, wrs);
      chk_i($sformatf("ill_op%0d", op), il, ills);
      next_instr(k);
   endtask

   typedef struct {
      logic [4:0] op;
      bit         con;
      int         len;
      int         rds;
      int         wrs;
      int         ills;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic [4:0] op;
      clear_a[0] = 1'b0; clear_a[1] = 1'b0;
      ir_a[0] = OP_NOP;  ir_a[1] = OP_NOP;
      con_a[0] = 1'b0;   con_a[1] = 1'b0;
      step = 1'b0;

      // MEM_WAIT=1, MULDIV_WAIT=2: cycles from T0 to instr_done inclusive
      tbl[0]  = '{OP_ADD,  1'b0, 7,  2, 0, 0};
      tbl[1]  = '{OP_ADDI, 1'b0, 7,  2, 0, 0};
      tbl[2]  = '{OP_LDI,  1'b0, 7,  2, 0, 0};
      tbl[3]  = '{OP_LD,   1'b0, 10, 4, 0, 0};
      tbl[4]  = '{OP_ST,   1'b0, 10, 2, 2, 0};
      tbl[5]  = '{OP_MUL,  1'b0, 10, 2, 0, 0};
      tbl[6]  = '{OP_NEG,  1'b0, 6,  2, 0, 0};
      tbl[7]  = '{OP_BR,   1'b1, 8,  2, 0, 0};
      tbl[8]  = '{OP_JR,   1'b0, 5,  2, 0, 0};
      tbl[9]  = '{OP_NOP,  1'b0, 4,  2, 0, 0};
      tbl[10] = '{5'd31,   1'b0, 4,  2, 0, 1};
      tbl[11] = '{OP_MFHI, 1'b0, 5,  2, 0, 0};

      repeat (2) @(negedge clk);
      chk("reset_u0", obs[0], '0);
      chk("reset_u1", obs[1], '0);

      rst(0);
      for (int i = 0; i < 12; i++)
         run_count(0, tbl[i].op, tbl[i].con, tbl[i].len, tbl[i].rds, tbl[i].wrs, tbl[i].ills);

      run_model(0, OP_ADD, 1'b0, 1, 2, 1'b1);
      run_model(0, OP_BR, 1'b0, 1, 2, 1'b1);
      run_model(0, OP_BR, 1'b1, 1, 2, 1'b1);
      run_model(0, 5'b11111, 1'b0, 1, 2, 1'b1);
      for (int i = 0; i < 50; i++) begin
         op = 5'($urandom_range(0, 31));
         if (op == OP_HALT) op = OP_DIV;
         run_model(0, op, 1'($urandom_range(0, 1)), 1, 2, 1'b1);
      end

      // abort a load while its read strobe is held
      ir_a[0] = OP_LD;
      repeat (7) tick();
      chk("ld_t6_read", {41'd0, obs[0][4]}, 42'd1);
      clear_a[0] = 1'b0;
      #1;
      chk("abort_async", obs[0], '0);
      @(negedge clk);
      clear_a[0] = 1'b1;
      chk("abort_rst", obs[0], '0);
      tick();
      chk("abort_t0", obs[0], PCOUT | MARIN | INCPC | ZIN | RUN);

      run_model(0, OP_HALT, 1'b0, 1, 2, 1'b0);
      rst(0);

`ifdef CTRL_SINGLE_STEP_EN
      run_model(0, OP_NOP, 1'b0, 1, 2, 1'b0);
      step = 1'b1;
      tick();
      run_model(0, OP_NOP, 1'b0, 1, 2, 1'b0);
      for (int i = 0; i < 6; i++) chk("held_step_pause", obs[0], RUN);
      for (int i = 0; i < 6; i++) if (i >= 0) tick();
      chk("held_step_end", obs[0], RUN);
      step = 1'b0;
      tick();
`endif

      clear_a[0] = 1'b0;
      rst(1);
      run_count(1, OP_ST, 1'b0, 14, 4, 4, 0);
      run_model(1, OP_ST, 1'b0, 3, 0, 1'b1);
      run_model(1, OP_LD, 1'b0, 3, 0, 1'b1);
      run_model(1, OP_MUL, 1'b0, 3, 0, 1'b1);
      run_model(1, OP_BR, 1'b0, 3, 0, 1'b1);
      run_model(1, OP_BR, 1'b1, 3, 0, 1'b1);
      for (int i = 0; i < 30; i++) begin
         op = 5'($urandom_range(0, 31));
         if (op == OP_HALT) op = OP_ST;
         run_model(1, op, 1'($urandom_range(0, 1)), 3, 0, 1'b1);
      end
      run_model(1, OP_HALT, 1'b0, 3, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
